// File: rtl/warships_ui_pkg.sv
// Shared types for the game-UI mouse click path: FSM states, target kinds,
// packed cell coordinates and the click-target record compared at press and release.
package warships_ui_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED_BTN,
      ARMED_CELL,
      DEAD
   } click_state_e;

   typedef enum logic [1:0] {
      NONE,
      BTN,
      CELL
   } target_kind_e;

   typedef struct packed {
      logic [3:0] col;
      logic [3:0] row;
   } cell_cor_t;

   // board/cor are kept zero unless kind == CELL so a whole-struct compare is exact
   typedef struct packed {
      target_kind_e kind;
      logic [1:0]   board;
      cell_cor_t    cor;
   } target_t;

   localparam int MAX_BOARDS = 4;

   function automatic int board_origin(input int x0, input int pitch, input int b);
      return x0 + b * pitch;
   endfunction

endpackage

// File: rtl/board_hit_test.sv
// Purpose: decides whether a pixel lies inside one square board grid and which cell it is.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module board_hit_test
   import warships_ui_pkg::*;
#(
   parameter int ORIGIN_X  = 100,
   parameter int ORIGIN_Y  = 200,
   parameter int GRID_N    = 10,
   parameter int CELL_LOG2 = 5
) (
   input  logic [11:0] x,
   input  logic [11:0] y,
   output logic        hit,
   output cell_cor_t   cor
);

   localparam int EXT = GRID_N << CELL_LOG2;

   logic [15:0] dx;
   logic [15:0] dy;

   // Offsets wrap negative (bit 15 set) when the pointer is left of / above the origin.
   assign dx = {4'b0, x} - 16'(ORIGIN_X);
   assign dy = {4'b0, y} - 16'(ORIGIN_Y);

   assign hit = !dx[15] && !dy[15] && (dx < 16'(EXT)) && (dy < 16'(EXT));

   assign cor.col = dx[CELL_LOG2 +: 4];
   assign cor.row = dy[CELL_LOG2 +: 4];

endmodule

// File: rtl/board_click_ctrl.sv
// Purpose: turns mouse position + left button into one-cycle start/cell click events and hover info.
// Latency: hover 2 edges after sampling; click event registered the edge after the release sample.
// Backpressure: none; events are single-cycle pulses with no handshake.
module board_click_ctrl
   import warships_ui_pkg::*;
#(
   parameter int NUM_BOARDS  = 2,
   parameter int GRID_N      = 10,
   parameter int CELL_LOG2   = 5,
   parameter int BOARD0_X    = 100,
   parameter int BOARD_PITCH = 438,
   parameter int GRID_Y      = 200,
   parameter int BTN_X       = 312,
   parameter int BTN_W       = 400,
   parameter int BTN_Y       = 600,
   parameter int BTN_H       = 64,
   localparam int BW         = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [11:0]           x_pos,
   input  logic [11:0]           y_pos,
   input  logic                  left,
   input  logic [NUM_BOARDS-1:0] board_en,
   output logic                  start_pulse,
   output logic                  cell_valid,
   output logic [BW-1:0]         cell_board,
   output logic [7:0]            cell_cor,
   output logic                  hover_valid,
   output logic [BW-1:0]         hover_board,
   output logic [7:0]            hover_cor
);

   logic [11:0] x_r;
   logic [11:0] y_r;
   logic        left_r;
   logic        left_prev;

   // left resets high so a button held through reset never looks like a fresh press
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r       <= '0;
         y_r       <= '0;
         left_r    <= 1'b1;
         left_prev <= 1'b1;
      end else begin
         x_r       <= x_pos;
         y_r       <= y_pos;
         left_r    <= left;
         left_prev <= left_r;
      end
   end

   logic press_edge;
   logic release_edge;

   assign press_edge   = left_r & ~left_prev;
   assign release_edge = ~left_r & left_prev;

   logic [NUM_BOARDS-1:0] bhit;
   cell_cor_t             bcor [NUM_BOARDS];

   for (genvar b = 0; b < NUM_BOARDS; b++) begin : g_hit
      board_hit_test #(
         .ORIGIN_X  (board_origin(BOARD0_X, BOARD_PITCH, b)),
         .ORIGIN_Y  (GRID_Y),
         .GRID_N    (GRID_N),
         .CELL_LOG2 (CELL_LOG2)
      ) u_hit (
         .x   (x_r),
         .y   (y_r),
         .hit (bhit[b]),
         .cor (bcor[b])
      );
   end

   logic btn_hit;

   assign btn_hit = ({1'b0, x_r} >= 13'(BTN_X)) && ({1'b0, x_r} < 13'(BTN_X + BTN_W)) &&
                    ({1'b0, y_r} >= 13'(BTN_Y)) && ({1'b0, y_r} < 13'(BTN_Y + BTN_H));

   logic          hov_vld;
   logic [BW-1:0] hov_board;
   cell_cor_t     hov_cor;
   target_t       cur;

   // Descending scan so the lowest-index enabled board wins on overlap.
   always_comb begin
      hov_vld   = 1'b0;
      hov_board = '0;
      hov_cor   = '0;
      for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
         if (bhit[b] && board_en[b]) begin
            hov_vld   = 1'b1;
            hov_board = BW'(b);
            hov_cor   = bcor[b];
         end
      end
   end

   always_comb begin
      cur.kind  = NONE;
      cur.board = '0;
      cur.cor   = '0;
      if (btn_hit) begin
         cur.kind = BTN;
      end else if (hov_vld) begin
         cur.kind  = CELL;
         cur.board = 2'(hov_board);
         cur.cor   = hov_cor;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hover_valid <= 1'b0;
         hover_board <= '0;
         hover_cor   <= '0;
      end else begin
         hover_valid <= hov_vld;
         hover_board <= hov_board;
         hover_cor   <= hov_cor;
      end
   end

   click_state_e state;
   target_t      armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         armed.kind  <= NONE;
         armed.board <= '0;
         armed.cor   <= '0;
         start_pulse <= 1'b0;
         cell_valid  <= 1'b0;
         cell_board  <= '0;
         cell_cor    <= '0;
      end else begin
         start_pulse <= 1'b0;
         cell_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (press_edge) begin
                  armed <= cur;
                  case (cur.kind)
                     BTN:     state <= ARMED_BTN;
                     CELL:    state <= ARMED_CELL;
                     default: state <= DEAD;
                  endcase
               end
            end
            ARMED_BTN, ARMED_CELL: begin
               // Any drift of the pointer (or a disabled board) between press and release cancels.
               if (release_edge) begin
                  state <= IDLE;
                  if (cur == armed) begin
                     if (state == ARMED_BTN) begin
                        start_pulse <= 1'b1;
                     end else begin
                        cell_valid <= 1'b1;
                        cell_board <= armed.board[BW-1:0];
                        cell_cor   <= armed.cor;
                     end
                  end
               end
            end
            DEAD: begin
               if (release_edge) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_click_ctrl.sv
// Directed bench for board_click_ctrl at default geometry (board extent 320 px).
module tb_board_click_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] x_pos;
   logic [11:0] y_pos;
   logic        left;
   logic [1:0]  board_en;
   logic        start_pulse;
   logic        cell_valid;
   logic [0:0]  cell_board;
   logic [7:0]  cell_cor;
   logic        hover_valid;
   logic [0:0]  hover_board;
   logic [7:0]  hover_cor;

   always #5 clk = ~clk;

   board_click_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .left        (left),
      .board_en    (board_en),
      .start_pulse (start_pulse),
      .cell_valid  (cell_valid),
      .cell_board  (cell_board),
      .cell_cor    (cell_cor),
      .hover_valid (hover_valid),
      .hover_board (hover_board),
      .hover_cor   (hover_cor)
   );

   int total = 0;
   int bad = 0;
   int both_cnt = 0;

   int         nc, ns, first_c;
   logic [7:0] cor_s;
   logic [0:0] bd_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Watches n falling edges, counting event pulses; index 0 is the edge right after the release sample.
   task automatic watch(input int n, output int o_nc, output int o_ns, output int o_first,
                        output logic [7:0] o_cor, output logic [0:0] o_bd);
      o_nc = 0; o_ns = 0; o_first = -1; o_cor = '0; o_bd = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cell_valid === 1'b1) begin
            o_nc++;
            if (o_first < 0) o_first = i;
            o_cor = cell_cor;
            o_bd  = cell_board;
         end
         if (start_pulse === 1'b1) begin
            o_ns++;
            if (o_first < 0) o_first = i;
         end
         if (start_pulse === 1'b1 && cell_valid === 1'b1) both_cnt++;
      end
   endtask

   task automatic click(input logic [11:0] px, input logic [11:0] py,
                        input logic [11:0] rx, input logic [11:0] ry);
      x_pos = px; y_pos = py; left = 1'b1;
      repeat (3) @(negedge clk);
      x_pos = rx; y_pos = ry; left = 1'b0;
      watch(5, nc, ns, first_c, cor_s, bd_s);
   endtask

   initial begin
      rst = 1'b1; x_pos = '0; y_pos = '0; left = 1'b0; board_en = 2'b11;
      repeat (2) @(negedge clk);
      chk("rst_start_pulse", start_pulse, 0);
      chk("rst_cell_valid",  cell_valid,  0);
      chk("rst_cell_board",  cell_board,  0);
      chk("rst_cell_cor",    cell_cor,    0);
      chk("rst_hover_valid", hover_valid, 0);
      chk("rst_hover_board", hover_board, 0);
      chk("rst_hover_cor",   hover_cor,   0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // board 0: dx=101 -> col 3, dy=225 -> row 7
      click(12'd201, 12'd425, 12'd201, 12'd425);
      chk("c0_count",  nc, 1);
      chk("c0_start",  ns, 0);
      chk("c0_cycle",  first_c, 1);
      chk("c0_board",  bd_s, 0);
      chk("c0_cor",    cor_s, 8'h37);
      chk("c0_held",   cell_cor, 8'h37);
      chk("c0_hov_v",  hover_valid, 1);
      chk("c0_hov_b",  hover_board, 0);
      chk("c0_hov_c",  hover_cor, 8'h37);

      // board 1 origin 538: dx=319 -> col 9, dy=0 -> row 0
      click(12'd857, 12'd200, 12'd857, 12'd200);
      chk("c1_count",  nc, 1);
      chk("c1_board",  bd_s, 1);
      chk("c1_cor",    cor_s, 8'h90);

      // x = origin + extent is just outside board 0
      click(12'd420, 12'd300, 12'd420, 12'd300);
      chk("edge_count", nc, 0);
      chk("edge_start", ns, 0);
      chk("edge_hov_v", hover_valid, 0);
      chk("edge_hov_c", hover_cor, 0);

      x_pos = 12'd857; y_pos = 12'd200;
      @(negedge clk);
      chk("hlat_early", hover_valid, 0);
      @(negedge clk);
      chk("hlat_v", hover_valid, 1);
      chk("hlat_b", hover_board, 1);
      chk("hlat_c", hover_cor, 8'h90);

      click(12'd400, 12'd620, 12'd700, 12'd663);
      chk("btn_start", ns, 1);
      chk("btn_cell",  nc, 0);
      chk("btn_cycle", first_c, 1);
      chk("btn_cor_held", cell_cor, 8'h90);

      click(12'd400, 12'd620, 12'd712, 12'd620);
      chk("btn_off_start", ns, 0);

      click(12'd201, 12'd425, 12'd233, 12'd425);
      chk("drag_count", nc, 0);

      // press on empty space, slide onto a cell, release
      x_pos = 12'd50; y_pos = 12'd50; left = 1'b1;
      repeat (2) @(negedge clk);
      x_pos = 12'd201; y_pos = 12'd425;
      repeat (3) @(negedge clk);
      left = 1'b0;
      watch(5, nc, ns, first_c, cor_s, bd_s);
      chk("dead_cell",  nc, 0);
      chk("dead_start", ns, 0);

      board_en = 2'b10;
      click(12'd201, 12'd425, 12'd201, 12'd425);
      chk("dis_count", nc, 0);
      chk("dis_hov_v", hover_valid, 0);
      board_en = 2'b11;

      x_pos = 12'd857; y_pos = 12'd200; left = 1'b1;
      repeat (3) @(negedge clk);
      board_en = 2'b01;
      left = 1'b0;
      watch(5, nc, ns, first_c, cor_s, bd_s);
      chk("en_drop_count", nc, 0);
      board_en = 2'b11;

      x_pos = 12'd201; y_pos = 12'd425; left = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_valid", cell_valid, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      left = 1'b0;
      watch(5, nc, ns, first_c, cor_s, bd_s);
      chk("midrst_count", nc, 0);
      chk("midrst_start", ns, 0);

      click(12'd201, 12'd425, 12'd201, 12'd425);
      chk("post_count", nc, 1);
      chk("post_cor",   cor_s, 8'h37);
      chk("post_board", bd_s, 0);

      chk("never_both", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_click_ctrl.md
# board_click_ctrl

Parametrised mouse-click controller for the game UI: converts the mouse position and left-button stream into one-cycle click events on N board grids and a start button. Successor of the single-cycle click decoder. It adds press/release click qualification, per-board enable masking, hover tracking and configurable geometry. It sits between the mouse interface and the game-logic FSM.

## Interface
- `NUM_BOARDS`, 2: number of board grids, 1..4
- `GRID_N`, 10: cells per board side, 1..16
- `CELL_LOG2`, 5: cell size is 2^CELL_LOG2 pixels
- `BOARD0_X`, 100: left pixel of board 0
- `BOARD_PITCH`, 438: x offset between consecutive boards
- `GRID_Y`, 200: top pixel of all boards
- `BTN_X`, 312 / `BTN_W`, 400 / `BTN_Y`, 600 / `BTN_H`, 64: start-button rectangle
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `x_pos`, `y_pos`  in  12 each  mouse position, pixels
- `left`  in  1  left button level, 1 = pressed
- `board_en`  in  NUM_BOARDS  per-board click enable
- `start_pulse`  out  1  one-cycle start-button click
- `cell_valid`  out  1  one-cycle board-cell click
- `cell_board`  out  BW = max(1, $clog2(NUM_BOARDS))  board index of the click
- `cell_cor`  out  8  {col[3:0], row[3:0]} of the click, held until the next click
- `hover_valid`  out  1  pointer is over a cell of an enabled board
- `hover_board`  out  BW  hovered board
- `hover_cor`  out  8  hovered {col, row}; 0 when `hover_valid` = 0

## Operation
- Stage 1 registers `x_pos`, `y_pos`, `left` and `left_prev` (the previous registered `left`).
- Hit test on the stage-1 registers, with extent E = GRID_N << CELL_LOG2:
  - Board b is hit when dx = x − (BOARD0_X + b·BOARD_PITCH) and dy = y − GRID_Y satisfy 0 ≤ dx < E and 0 ≤ dy < E, using exclusive upper bounds and unsigned compare after a sign check. It must also have `board_en[b]` = 1.
  - col = dx >> CELL_LOG2, row = dy >> CELL_LOG2. The lowest index wins if boards overlap.
  - The button is hit when BTN_X ≤ x < BTN_X+BTN_W and BTN_Y ≤ y < BTN_Y+BTN_H. The button has priority over boards.
- Target = {kind ∈ NONE/BTN/CELL, board, cor}.
- FSM states and transitions:
  - IDLE: on press edge (left & !left_prev), go to ARMED_BTN, ARMED_CELL (latching the target) or DEAD if the target is NONE.
  - ARMED_*: while held, stay. On release edge, fire only if the current target equals the latched target (same board and same cor, or BTN). Then return to IDLE.
  - DEAD: wait for release, then return to IDLE. No event.
- Dragging to a different cell or off the target before release cancels the click.
- If `board_en` is deasserted while ARMED_CELL, the release target no longer matches, so there is no event.
- Event outputs are registered. `cell_cor`/`cell_board` update only when `cell_valid` fires.

## Timing
- Reset: all outputs 0. State is IDLE. Stage-1 x/y are 0. `left` and `left_prev` reset to 1, so a button held through reset must be released and pressed again to count.
- Hover latency: position sampled at edge k appears on the hover outputs after edge k+1. Hover updates every cycle, independent of the FSM.
- Click latency: if `left` is first sampled low at edge k, `start_pulse`/`cell_valid` are high for exactly the cycle after edge k+1.
- A press and release on consecutive samples is a valid click. There is no minimum hold.
- At most one event per release. `start_pulse` and `cell_valid` are never high together.
- Reset mid-press: FSM goes to IDLE, no event.

## Structure
- Package `warships_ui_pkg` holds:
  - `click_state_e` (IDLE, ARMED_BTN, ARMED_CELL, DEAD)
  - `target_kind_e` (NONE, BTN, CELL)
  - `cell_cor_t` packed {col[3:0], row[3:0]}
  - the target struct
- Sub-module `board_hit_test`: combinational, one per board via generate. Parameters are the board origin, GRID_N and CELL_LOG2. Outputs hit and cor.

## Test plan
Defaults apply, E = 320.
- Press/release at (201,425) → one `cell_valid`, `cell_board`=0, `cell_cor`=8'h37, 2 cycles after release sample; hover shows the same values.
- Click at (857,200) → `cell_board`=1, `cell_cor`=8'h90. Click at (420,300) (x = origin+E) → no event, `hover_valid`=0.
- Press (400,620), release (700,663) → `start_pulse` for one cycle. Release at (712,620) instead → no pulse.
- Press (201,425), drag and release at (233,425) → no event. Press outside all targets, then move onto a cell and release → no event (DEAD).
- `board_en`=2'b10, click board-0 cell → no event. Drop `board_en[1]` during an ARMED board-1 press → no event.
- Assert `rst` mid-press with `left` still held, then release → no event. A subsequent fresh click produces a normal event.
